// File: rtl/rata_lmt_unit.sv
// rata_lmt_unit: hardware-owned Latest-Modification-Time register for RATA_B.
// Snoops CPU (and, with RATA_DMA_EN defined, DMA) writes into registered
// Mod_Mem_LMT / Mod_Mem_AR pulses, runs a saturating timestamp ts, and on each
// UP_LMT assertion commits ts into lmt exactly once, pulsing upd_done.
// Ports: clk, rst (async, active-high), dmem_wen/dmem_addr, dma_en/dma_addr
// (RATA_DMA_EN only), UP_LMT; outputs Mod_Mem_LMT, Mod_Mem_AR, lmt, ts, upd_done.
module rata_lmt_unit #(
  parameter int                ADDR_W    = 16,
  parameter int                TS_W      = 32,
  parameter logic [ADDR_W-1:0] AR_MIN    = 16'h0400,
  parameter logic [ADDR_W-1:0] AR_MAX    = 16'h07FF,
  parameter logic [ADDR_W-1:0] LMT_BASE  = 16'h0140,
  parameter int                LMT_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dmem_wen,
  input  logic [ADDR_W-1:0] dmem_addr,
`ifdef RATA_DMA_EN
  input  logic              dma_en,
  input  logic [ADDR_W-1:0] dma_addr,
`endif
  input  logic              UP_LMT,
  output logic              Mod_Mem_LMT,
  output logic              Mod_Mem_AR,
  output logic [TS_W-1:0]   lmt,
  output logic [TS_W-1:0]   ts,
  output logic              upd_done
);
  localparam logic [ADDR_W-1:0] LMT_LAST = ADDR_W'(LMT_BASE + LMT_BYTES - 1);
  typedef enum logic [1:0] {IDLE, COMMIT, HOLD} state_t;
  state_t state_q, state_d;
  logic [TS_W-1:0] ts_q, ts_d, lmt_q, lmt_d;
  logic hit_lmt, hit_ar, done_d, mod_lmt_q, mod_ar_q, done_q;
  always_comb begin
    hit_lmt = dmem_wen && dmem_addr >= LMT_BASE && dmem_addr <= LMT_LAST;
    hit_ar  = dmem_wen && dmem_addr >= AR_MIN && dmem_addr <= AR_MAX;
`ifdef RATA_DMA_EN
    hit_lmt = hit_lmt || (dma_en && dma_addr >= LMT_BASE && dma_addr <= LMT_LAST);
    hit_ar  = hit_ar || (dma_en && dma_addr >= AR_MIN && dma_addr <= AR_MAX);
`endif
  end
  // Saturating so a stale LMT value can never reappear after a wrap.
  assign ts_d = &ts_q ? ts_q : ts_q + 1'b1;
  // One commit per request: HOLD swallows the rest of a long UP_LMT level.
  always_comb begin
    state_d = state_q == IDLE   ? (UP_LMT ? COMMIT : IDLE) :
              state_q == COMMIT ? HOLD :
                                  (UP_LMT ? HOLD : IDLE);
    lmt_d   = state_q == COMMIT ? ts_q : lmt_q;
    done_d  = state_q == COMMIT;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ts_q      <= '0;
      lmt_q     <= '0;
      done_q    <= 1'b0;
      mod_lmt_q <= 1'b0;
      mod_ar_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ts_q      <= ts_d;
      lmt_q     <= lmt_d;
      done_q    <= done_d;
      mod_lmt_q <= hit_lmt;
      mod_ar_q  <= hit_ar;
    end
  end
  assign Mod_Mem_LMT = mod_lmt_q;
  assign Mod_Mem_AR  = mod_ar_q;
  assign lmt         = lmt_q;
  assign ts          = ts_q;
  assign upd_done    = done_q;
endmodule

// File: tb/tb_rata_lmt_unit.sv
// tb_rata_lmt_unit: directed plus random checks of rata_lmt_unit against a behavioural model.
module tb_rata_lmt_unit;
  logic clk = 1'b0, rst = 1'b1, wen = 1'b0, up = 1'b0;
  logic [15:0] addr = '0;
`ifdef RATA_DMA_EN
  logic dma_en = 1'b0;
  logic [15:0] dma_addr = '0;
`endif
  logic mod_l, mod_a, done, mod_l8, mod_a8, done8;
  logic [31:0] lmt, ts;
  logic [7:0] lmt8, ts8;
  int ncmp = 0, nerr = 0;
  logic [31:0] m_ts, m_lmt, cap;
  bit m_fl, m_fa, m_done, busy;
  int edge_n, acc;

  always #5 clk = ~clk;

  rata_lmt_unit dut (
    .clk(clk), .rst(rst), .dmem_wen(wen), .dmem_addr(addr),
`ifdef RATA_DMA_EN
    .dma_en(dma_en), .dma_addr(dma_addr),
`endif
    .UP_LMT(up), .Mod_Mem_LMT(mod_l), .Mod_Mem_AR(mod_a),
    .lmt(lmt), .ts(ts), .upd_done(done)
  );

  rata_lmt_unit #(.TS_W(8)) dut8 (
    .clk(clk), .rst(rst), .dmem_wen(wen), .dmem_addr(addr),
`ifdef RATA_DMA_EN
    .dma_en(dma_en), .dma_addr(dma_addr),
`endif
    .UP_LMT(up), .Mod_Mem_LMT(mod_l8), .Mod_Mem_AR(mod_a8),
    .lmt(lmt8), .ts(ts8), .upd_done(done8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_rng(input logic [15:0] a, input logic [15:0] lo, input logic [15:0] hi);
    return a >= lo && a <= hi;
  endfunction

  // Model: a request is accepted on an edge where UP_LMT is high and no earlier
  // request is still outstanding; the following edge writes the timestamp seen
  // just after acceptance. The request stays outstanding until UP_LMT is seen
  // low at least two edges after acceptance.
  task automatic tick();
    bit hl, ha;
    @(posedge clk);
    hl = wen && in_rng(addr, 16'h0140, 16'h0143);
    ha = wen && in_rng(addr, 16'h0400, 16'h07FF);
`ifdef RATA_DMA_EN
    hl = hl || (dma_en && in_rng(dma_addr, 16'h0140, 16'h0143));
    ha = ha || (dma_en && in_rng(dma_addr, 16'h0400, 16'h07FF));
`endif
    m_fl = hl;
    m_fa = ha;
    m_done = 1'b0;
    if (busy && edge_n == acc + 1) begin
      m_lmt = cap;
      m_done = 1'b1;
    end
    if (busy && edge_n >= acc + 2 && !up) busy = 1'b0;
    else if (!busy && up) begin
      busy = 1'b1;
      acc = edge_n;
      cap = (m_ts == 32'hFFFF_FFFF) ? m_ts : m_ts + 1;
    end
    m_ts = (m_ts == 32'hFFFF_FFFF) ? m_ts : m_ts + 1;
    edge_n++;
    #1;
    chk("ts", ts, m_ts);
    chk("lmt", lmt, m_lmt);
    chk("mod_lmt", mod_l, m_fl);
    chk("mod_ar", mod_a, m_fa);
    chk("upd_done", done, m_done);
    chk("mod_lmt8", mod_l8, m_fl);
    chk("mod_ar8", mod_a8, m_fa);
    chk("upd_done8", done8, m_done);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_ts", ts, 0);
    chk("rst_lmt", lmt, 0);
    chk("rst_mod_lmt", mod_l, 0);
    chk("rst_mod_ar", mod_a, 0);
    chk("rst_done", done, 0);
    chk("rst_ts8", ts8, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    m_ts = 0; m_lmt = 0; cap = 0; m_fl = 0; m_fa = 0; m_done = 0; busy = 0;
    edge_n = 0; acc = 0;
  endtask

  initial begin
    logic [15:0] ab [4];
    bit ae [4];
    int nd, guard;
    logic [31:0] first_lmt;
    ab = '{16'h03FF, 16'h0800, 16'h0400, 16'h07FF};
    ae = '{1'b0, 1'b0, 1'b1, 1'b1};
    #2;
    do_reset();
    repeat (5) tick();
    chk("ts_after5", ts, 5);
    wen = 1'b1; addr = 16'h0142;
    tick();
    wen = 1'b0;
    chk("lmtwr_flag", mod_l, 1);
    chk("lmtwr_ar", mod_a, 0);
    chk("lmtwr_lmt", lmt, 0);
    tick();
    chk("lmtwr_flag_end", mod_l, 0);
    for (int i = 0; i < 4; i++) begin
      wen = 1'b1; addr = ab[i];
      tick();
      chk("ar_bound", mod_a, ae[i]);
    end
    wen = 1'b0;
    tick();
    guard = 0;
    while (ts !== 32'd100 && guard < 200) begin
      tick();
      guard++;
    end
    chk("reach_ts100", ts, 100);
    up = 1'b1;
    nd = 0;
    repeat (20) begin
      tick();
      nd += int'(done);
    end
    up = 1'b0;
    tick();
    chk("held_lmt", lmt, 101);
    chk("held_single_done", nd, 1);
    first_lmt = m_lmt;
    repeat (3) tick();
    up = 1'b1;
    repeat (2) tick();
    up = 1'b0;
    chk("second_done", done, 1);
    chk("second_larger", lmt > first_lmt, 1);
    repeat (2) tick();
    up = 1'b1;
    tick();
    up = 1'b0; wen = 1'b1; addr = 16'h0140;
    tick();
    wen = 1'b0;
    chk("coll_flag", mod_l, 1);
    chk("coll_done", done, 1);
    chk("coll_lmt", lmt, cap);
    tick();
`ifdef RATA_DMA_EN
    dma_en = 1'b1; dma_addr = 16'h0500;
    tick();
    dma_en = 1'b0;
    chk("dma_ar", mod_a, 1);
    tick();
`endif
    repeat (400) begin
      case ($urandom % 4)
        0: addr = 16'($urandom);
        1: addr = 16'h013E + 16'($urandom % 8);
        2: addr = 16'h03FE + 16'($urandom % 4);
        default: addr = 16'h07FD + 16'($urandom % 4);
      endcase
      wen = 1'($urandom % 2);
      if ($urandom % 4 == 0) up = ~up;
`ifdef RATA_DMA_EN
      dma_en = 1'($urandom % 2);
      dma_addr = ($urandom % 2) ? 16'h0141 : 16'h0400 + 16'($urandom % 2048);
`endif
      tick();
    end
    wen = 1'b0; up = 1'b0;
`ifdef RATA_DMA_EN
    dma_en = 1'b0;
`endif
    repeat (3) tick();
    up = 1'b1;
    tick();
    up = 1'b0;
    do_reset();
    repeat (3) tick();
    chk("abort_lmt", lmt, 0);
    repeat (260) tick();
    chk("sat_ts8", ts8, 8'hFF);
    up = 1'b1;
    repeat (2) tick();
    up = 1'b0;
    tick();
    chk("sat_ts8_hold", ts8, 8'hFF);
    chk("sat_lmt8", lmt8, 8'hFF);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/rata_lmt_unit.md
# rata_lmt_unit

Latest-Modification-Time (LMT) unit for the RATA_B attestation monitor. It is the other end of the RATA_B interface: it produces the `Mod_Mem_LMT` and `Mod_Mem_AR` modification flags that RATA_B consumes by snooping CPU and DMA writes. It consumes RATA_B's `UP_LMT` request and commits a fresh timestamp into the hardware-owned LMT register. Software can read LMT but can never write it.

## Interface
- `ADDR_W`, 16, data-memory address width
- `TS_W`, 32, timestamp and LMT width
- `AR_MIN`, 16'h0400, first byte address of the attested region (AR), inclusive
- `AR_MAX`, 16'h07FF, last byte address of AR, inclusive
- `LMT_BASE`, 16'h0140, first byte address of the memory-mapped LMT window
- `LMT_BYTES`, 4, size in bytes of the LMT window

Ports:
- `clk`  in  1  system clock; single clock domain
- `rst`  in  1  reset; asynchronous, active-high
- `dmem_wen`  in  1  CPU data-memory write strobe
- `dmem_addr`  in  ADDR_W  CPU write address
- `dma_en`  in  1  DMA write strobe (only with `RATA_DMA_EN`)
- `dma_addr`  in  ADDR_W  DMA write address (only with `RATA_DMA_EN`)
- `UP_LMT`  in  1  update request from RATA_B, a level held while RATA_B is in UPDATE
- `Mod_Mem_LMT`  out  1  one-cycle pulse: a write hit the LMT window
- `Mod_Mem_AR`  out  1  one-cycle pulse: a write hit AR
- `lmt`  out  TS_W  current LMT value, read-only to software
- `ts`  out  TS_W  free-running timestamp
- `upd_done`  out  1  one-cycle pulse: LMT commit completed

## Operation
- **Timestamp counter**
  - `ts` increments by 1 every cycle.
  - It saturates at all-ones and never wraps, so an old LMT value can never recur.
- **Write snooping**
  - A write hits when its strobe is high and its address lies in the window. Comparisons are unsigned and inclusive.
  - LMT window: `LMT_BASE` ≤ addr ≤ `LMT_BASE+LMT_BYTES-1`.
  - AR window: `AR_MIN` ≤ addr ≤ `AR_MAX`.
  - Hits from the CPU and DMA ports are ORed, then registered. Each output pulses for exactly one cycle per cycle with a hit.
  - Back-to-back hits give continuous high.
  - Software writes never change `lmt`; they only raise `Mod_Mem_LMT`.
- **Update FSM** (`IDLE`, `COMMIT`, `HOLD`):
  - `IDLE`: if `UP_LMT`=1, go to `COMMIT`.
  - `COMMIT`:
    - `lmt` ← `ts` as sampled in the cycle `COMMIT` was entered.
    - `upd_done` pulses.
    - Next state is `HOLD`.
  - `HOLD`: wait until `UP_LMT`=0, then go to `IDLE`.
  - Exactly one commit occurs per `UP_LMT` assertion, regardless of how long the request is held.
- **Simultaneous events**
  - A hardware commit and a software LMT write in the same cycle: the commit updates `lmt` and `Mod_Mem_LMT` still pulses.
  - An AR write and an LMT write in the same cycle: both flags pulse.
- The FSM does not depend on the snoop flags. RATA_B decides policy.

## Timing
- Reset values:
  - `ts`=0, `lmt`=0
  - `Mod_Mem_LMT`=0, `Mod_Mem_AR`=0, `upd_done`=0
  - FSM in `IDLE`
- Snoop latency: a hit at edge N produces the flag high from edge N+1 to edge N+2.
- Update latency:
  - `UP_LMT` sampled high at edge N: FSM enters `COMMIT` at N+1 and captures `ts`(N+1).
  - `lmt` and `upd_done` update at edge N+2.
  - `upd_done` is high for the single cycle between edges N+2 and N+3.
- `UP_LMT` dropping during `COMMIT` does not abort the commit; the FSM then passes through `HOLD` for one cycle.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronously). A pending commit is discarded.
- Saturation: at `ts`=all-ones, `ts` holds, and a commit captures all-ones.

## Configuration
- Macro: `RATA_DMA_EN`.
- Defined: `dma_en` and `dma_addr` exist and DMA hits are ORed into both snoop flags.
- Undefined: the DMA ports are absent and only CPU writes are snooped.
- All other behaviour is identical.

## Test plan
- **Reset:** assert `rst` for 3 cycles, release → all outputs 0; `ts` reads 5 after 5 cycles.
- **LMT write:** `dmem_wen`=1, `dmem_addr`=16'h0142 for 1 cycle → `Mod_Mem_LMT` high for exactly 1 cycle, one cycle later; `lmt` unchanged at 0; `Mod_Mem_AR`=0.
- **AR boundaries:**
  - writes to 16'h03FF and 16'h0800 → no flags;
  - writes to 16'h0400 and 16'h07FF → `Mod_Mem_AR` pulses for each.
- **Held update:** hold `UP_LMT`=1 for 20 cycles starting when `ts`=100 → `lmt`=101, a single `upd_done` pulse; a second assertion later commits a new, larger value.
- **Collision:** software write to 16'h0140 in the same cycle as `COMMIT` → `lmt` equals the committed `ts` and `Mod_Mem_LMT` pulses.
- **DMA path:** with `RATA_DMA_EN`, `dma_en`=1, `dma_addr`=16'h0500 → `Mod_Mem_AR` pulses; the same stimulus with the macro undefined does not compile the ports. Also force `ts` near saturation → it holds at all-ones.
